ser_tx4: RTL and testbench

SER_TX4 -- requirements
Module: ser_tx4

---
 rtl/ser_tx4.sv | 142 ++++++++++++++
 tb/tb_ser_tx4.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ser_tx4.sv
// ser_tx4: 4-bit parallel-to-serial transmitter.
// Frame = start bit (0), D[0..3] LSB first, stop bit (1); each bit lasts DIV
// clk cycles. EN=0 freezes the frame in place; done pulses once per frame.
module ser_tx4 #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       EN,
    input  logic [3:0] D,
    input  logic       load,
    output logic       ready,
    output logic       busy,
    output logic       TX,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Last count value of a bit period; DIV=256 maps to 255, the top of the counter.
    localparam logic [7:0] CNT_LAST = 8'(DIV - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] bit_cnt;
    logic [1:0] bit_idx;
    logic [3:0] shreg;
    logic       accept;
    logic       bit_end;
    logic       frame_end;

    assign ready = (state == IDLE);
    assign busy  = ~ready;

    // Next-state decode; nothing advances while EN is low.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        bit_end    = (bit_cnt == CNT_LAST);
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                if (EN && load) begin
                    accept     = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (EN && bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (EN && bit_end && (bit_idx == 2'd3)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (EN && bit_end) begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: bit timing, shift register and registered line; TX only moves at bit boundaries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= 8'd0;
            bit_idx <= 2'd0;
            shreg   <= 4'b0000;
            TX      <= 1'b1;
            done    <= 1'b0;
        end else begin
            // done is a single-cycle strobe and clears regardless of EN
            done <= frame_end;
            if (EN) begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            shreg   <= D;
                            bit_cnt <= 8'd0;
                            bit_idx <= 2'd0;
                            TX      <= 1'b0;
                        end
                    end
                    START: begin
                        if (bit_end) begin
                            bit_cnt <= 8'd0;
                            bit_idx <= 2'd0;
                            TX      <= shreg[0];
                            shreg   <= {1'b0, shreg[3:1]};
                        end else begin
                            bit_cnt <= bit_cnt + 8'd1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            bit_cnt <= 8'd0;
                            if (bit_idx == 2'd3) begin
                                TX <= 1'b1;
                            end else begin
                                TX      <= shreg[0];
                                shreg   <= {1'b0, shreg[3:1]};
                                bit_idx <= bit_idx + 2'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 8'd1;
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            bit_cnt <= 8'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 8'd1;
                        end
                    end
                    default: begin
                        bit_cnt <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ser_tx4.sv
// Testbench for ser_tx4: two instances (DIV=4 and DIV=1) share one stimulus.
// A frame-level model (remaining cycles per frame) predicts every output.
module tb_ser_tx4;

    logic       clk = 1'b0;
    logic       reset;
    logic       EN;
    logic [3:0] D;
    logic       load;

    logic ready4, busy4, tx4, done4;
    logic ready1, busy1, tx1, done1;

    int compared   = 0;
    int mismatched = 0;

    // Model state: cycles left in the current frame, captured word, done strobe.
    int       rem   [2] = '{0, 0};
    logic [3:0] wrd [2];
    logic     mdone [2] = '{1'b0, 1'b0};

    ser_tx4 #(.DIV(4)) u_dut4 (
        .clk(clk), .reset(reset), .EN(EN), .D(D), .load(load),
        .ready(ready4), .busy(busy4), .TX(tx4), .done(done4)
    );

    ser_tx4 #(.DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .EN(EN), .D(D), .load(load),
        .ready(ready1), .busy(busy1), .TX(tx1), .done(done1)
    );

    always #5 clk = ~clk;

    function automatic int dv(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Expected line level from position within the frame.
    function automatic logic exp_tx(input int i);
        int el;
        int b;
        if (rem[i] == 0) return 1'b1;
        el = 6 * dv(i) - rem[i];
        b  = el / dv(i);
        if (b == 0) return 1'b0;
        if (b < 5) return wrd[i][b-1];
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: accept starts a 6*DIV-cycle frame, each enabled edge consumes one cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                rem[i]   <= 0;
                mdone[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                mdone[i] <= EN && (rem[i] == 1);
                if (EN) begin
                    if (rem[i] == 0) begin
                        if (load) begin
                            rem[i] <= 6 * dv(i);
                            wrd[i] <= D;
                        end
                    end else begin
                        rem[i] <= rem[i] - 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("tx4",    tx4,    exp_tx(0));
        chk("ready4", ready4, rem[0] == 0);
        chk("busy4",  busy4,  rem[0] != 0);
        chk("done4",  done4,  mdone[0]);
        chk("tx1",    tx1,    exp_tx(1));
        chk("ready1", ready1, rem[1] == 0);
        chk("busy1",  busy1,  rem[1] != 0);
        chk("done1",  done1,  mdone[1]);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] p24;
        logic [13:0] p14t;
        logic [13:0] p14r;
        logic [26:0] p27;

        reset = 1'b1;
        EN    = 1'b1;
        D     = 4'b0000;
        load  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx4",    tx4,    1'b1);
        chk("rst_ready4", ready4, 1'b1);
        chk("rst_busy4",  busy4,  1'b0);
        chk("rst_done4",  done4,  1'b0);

        // Basic frame DIV=4, D=1010; load present on first edge after reset release
        reset = 1'b0;
        D     = 4'b1010;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        p24 = 24'b0000_0000_1111_0000_1111_1111;
        for (int n = 0; n < 24; n++) begin
            chk("basic_tx4", tx4, p24[23-n]);
            @(negedge clk);
        end
        chk("basic_done4",  done4,  1'b1);
        chk("basic_ready4", ready4, 1'b1);
        @(negedge clk);
        chk("basic_done4_clear", done4, 1'b0);
        repeat (30) @(negedge clk);

        // Back-to-back frames with load held high, DIV=1
        D    = 4'b0111;
        load = 1'b1;
        @(negedge clk);
        p14t = 14'b01110110111011;
        p14r = 14'b00000010000001;
        for (int n = 0; n < 14; n++) begin
            chk("b2b_tx1",    tx1,    p14t[13-n]);
            chk("b2b_ready1", ready1, p14r[13-n]);
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        load = 1'b0;
        repeat (30) @(negedge clk);

        // Data change and load while busy are ignored
        D    = 4'b0001;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        p24 = 24'b0000_1111_0000_0000_0000_1111;
        for (int n = 0; n < 24; n++) begin
            if (n == 5) begin
                D    = 4'b1110;
                load = 1'b1;
            end
            if (n == 6) load = 1'b0;
            chk("busyload_tx4", tx4, p24[23-n]);
            @(negedge clk);
        end
        chk("busyload_ready4", ready4, 1'b1);
        repeat (3) @(negedge clk);
        chk("busyload_noframe_ready4", ready4, 1'b1);
        chk("busyload_noframe_tx4",    tx4,    1'b1);
        repeat (30) @(negedge clk);

        // EN low for 3 cycles during D[1] stretches that bit to 7 cycles
        D    = 4'b1010;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        p27 = 27'b00000000_1111111_0000_11111111;
        for (int n = 0; n < 27; n++) begin
            if (n == 9)  EN = 1'b0;
            if (n == 12) EN = 1'b1;
            chk("stall_tx4", tx4, p27[26-n]);
            if (n == 26) chk("stall_ready4_late", ready4, 1'b0);
            @(negedge clk);
        end
        chk("stall_ready4", ready4, 1'b1);
        chk("stall_done4",  done4,  1'b1);
        EN = 1'b0;
        @(negedge clk);
        chk("stall_done4_clear_en0", done4,  1'b0);
        chk("stall_ready4_en0",      ready4, 1'b1);
        EN = 1'b1;
        repeat (30) @(negedge clk);

        // Asynchronous reset mid-frame, then clean frame on the next edge
        D    = 4'b0000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_pre_tx4", tx4, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("abort_tx4",    tx4,    1'b1);
        chk("abort_ready4", ready4, 1'b1);
        chk("abort_busy4",  busy4,  1'b0);
        chk("abort_done4",  done4,  1'b0);
        chk("abort_tx1",    tx1,    1'b1);
        chk("abort_ready1", ready1, 1'b1);
        D    = 4'b0110;
        load = 1'b1;
        #1 reset = 1'b0;
        @(negedge clk);
        load = 1'b0;
        p24 = 24'b0000_0000_1111_1111_0000_1111;
        for (int n = 0; n < 24; n++) begin
            chk("postrst_tx4", tx4, p24[23-n]);
            @(negedge clk);
        end
        chk("postrst_done4", done4, 1'b1);
        repeat (30) @(negedge clk);

        // EN low in IDLE blocks acceptance until EN returns
        EN   = 1'b0;
        D    = 4'b1001;
        load = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("en0idle_ready4", ready4, 1'b1);
            chk("en0idle_tx4",    tx4,    1'b1);
        end
        EN = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("en1_accept_ready4", ready4, 1'b0);
        chk("en1_accept_tx4",    tx4,    1'b0);
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
